// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: word-aligned multi-cycle memory access,
// read-modify-write for sub-word stores, lane extraction and extension for loads.
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        misalign_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          fault_q, fault_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   word_q, word_d;

  logic          req_fault;
  logic [31:0]   merged;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_data;

  assign req_fault = (req_size_i == 2'b11)
                   | ((req_size_i == 2'b01) & req_addr_i[0])
                   | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00));

  // word_q holds the raw store data until the read phase overwrites it
  always_comb begin
    merged = mem_data_i;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
    else if (size_q == 2'b01)
      merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
  end

  always_comb begin
    ld_b = word_q[{addr_q[1:0], 3'b000} +: 8];
    ld_h = word_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_data = uns_q ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_data = word_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    fault_d      = fault_q;
    addr_d       = addr_q;
    word_d       = word_q;
    stall_o      = 1'b0;
    resp_valid_o = 1'b0;
    resp_data_o  = 32'h0;
    misalign_o   = 1'b0;
    mem_addr_o   = 32'h0;
    mem_wdata_o  = 32'h0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          stall_o = 1'b1;
          wr_d    = req_write_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          fault_d = req_fault;
          addr_d  = req_addr_i;
          word_d  = req_wdata_i;
          cnt_d   = CNT_INIT;
          if (req_fault)
            state_d = RESP;
          else if (req_write_i && req_size_i == 2'b10)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        stall_o    = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
        if (cnt_q == '0) begin
          word_d  = wr_q ? merged : mem_data_i;
          cnt_d   = CNT_INIT;
          state_d = wr_q ? WR : RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        stall_o     = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = word_q;
        if (cnt_q == '0)
          state_d = RESP;
        else
          cnt_d = cnt_q - 1'b1;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        misalign_o   = fault_q;
        resp_data_o  = (fault_q | wr_q) ? 32'h0 : ld_data;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

endmodule
